// File: rtl/gate2_truth_checker.sv
// Stimulus/response checker for a two-input, one-output gate: walks {a,b} through 00..11,
// samples z after a settle interval and scores it against EXPECTED. Option: GATE_CHECK_HALT_EN.
module gate2_truth_checker #(
  parameter int         SETTLE_CYCLES = 10,
  parameter logic [3:0] EXPECTED      = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

`ifdef GATE_CHECK_HALT_EN
  localparam logic HALT_ON_ERR = 1'b1;
`else
  localparam logic HALT_ON_ERR = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic       mismatch;

  // Case-inequality so that an X or Z on the gate output is scored as a failure.
  assign mismatch = (z !== EXPECTED[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 2'd0;
          ab_d    = 2'b00;
          cnt_d   = 8'd0;
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        err_d  = err_q + 3'(mismatch);
        mask_d = mask_q | (4'(mismatch) << idx_q);
        if ((idx_q == 2'd3) || (HALT_ON_ERR && mismatch)) begin
          state_d = DONE;
          ab_d    = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 2'd1;
          ab_d    = idx_q + 2'd1;
          cnt_d   = 8'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
